// File: rtl/ai_shot_engine.sv
// ai_shot_engine: memory-mapped AI opponent shot generator for a square board.
//   Hunt mode scans untried cells from an LFSR-derived start index; target
//   mode pops neighbours of reported hits from a LIFO stack.
//   Optional macro AI_PARITY_HUNT_EN: hunt first accepts only (x+y)-even cells,
//   then re-scans accepting any untried cell if none was found.
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   addr, write_en, read_en - register select and access strobes
//   data_in                 - write data
//   wait_request            - high while busy (access not accepted)
//   data_out                - read data of the accepted read, else 0
// Registers: 0 CTRL(W) 1 SEED(W) 2 RESULT(W) 3 SHOT(R) 4 STATUS(R)
module ai_shot_engine #(
   parameter int BOARD_DIM   = 10,
   parameter int STACK_DEPTH = 16,
   parameter int DATA_W      = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [3:0]        addr,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [DATA_W-1:0] data_in,
   output logic              wait_request,
   output logic [DATA_W-1:0] data_out
);

   localparam int N     = BOARD_DIM * BOARD_DIM;
   localparam int IDX_W = $clog2(N);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int SA_W  = $clog2(STACK_DEPTH);
   localparam logic [7:0]       DMAX     = 8'(BOARD_DIM - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);
`ifdef AI_PARITY_HUNT_EN
   localparam bit PARITY_HUNT = 1'b1;
`else
   localparam bit PARITY_HUNT = 1'b0;
`endif

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_HUNT, S_TARGET, S_DONE} state_t;

   state_t state, next_state;

   logic [N-1:0]       tried;
   logic [15:0]        lfsr, lfsr_next;
   logic               shot_valid, shot_mode;
   logic [7:0]         shot_x, shot_y;
   logic [15:0]        shot_count;
   logic [15:0]        stack_q [STACK_DEPTH];
   logic [15:0]        stack_d [STACK_DEPTH];
   logic [SP_W-1:0]    sp_q, sp_d, sp_top;
   logic [IDX_W-1:0]   clr_idx, scan_idx, scan_cnt;
   logic [7:0]         scan_x, scan_y;
   logic               scan_phase2;

   logic               acc_wr, acc_rd, ctrl_wr, clear_req, start_req;
   logic               seed_wr, result_wr, result_apply;
   logic [IDX_W-1:0]   start_idx;
   logic [7:0]         start_x, start_y;
   logic [15:0]        top_ent;
   logic [IDX_W-1:0]   top_idx;
   logic               eligible;
   logic [3:0]         nb_ok;
   logic [15:0]        nb_ent [4];

   logic               do_issue, iss_mode, do_pop, hunt_load, scan_step;
   logic               phase_set, hunt_fail;
   logic [7:0]         iss_x, iss_y;
   logic [IDX_W-1:0]   iss_idx;
   logic [31:0]        rdata;
   logic               unused_hi;

   function automatic logic [IDX_W-1:0] idx_of(input logic [7:0] x, input logic [7:0] y);
      int v;
      v = int'(y) * BOARD_DIM + int'(x);
      return IDX_W'(v);
   endfunction

   // ---------------- bus decode ----------------
   assign wait_request = (state != S_IDLE);
   assign acc_wr       = write_en && !wait_request;
   assign acc_rd       = read_en && !wait_request;
   assign ctrl_wr      = acc_wr && (addr == 4'd0);
   assign clear_req    = ctrl_wr && data_in[1];
   assign start_req    = ctrl_wr && data_in[0] && !data_in[1];
   assign seed_wr      = acc_wr && (addr == 4'd1);
   assign result_wr    = acc_wr && (addr == 4'd2);
   assign result_apply = result_wr && shot_valid;
   assign unused_hi    = ^data_in[DATA_W-1:16];

   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // Low LFSR bits are < 2N, so a single conditional subtract folds them into range.
   always_comb begin
      int v;
      v = int'(lfsr[IDX_W-1:0]);
      if (v >= N) v = v - N;
      start_idx = IDX_W'(v);
      start_x   = 8'(v % BOARD_DIM);
      start_y   = 8'(v / BOARD_DIM);
   end

   assign sp_top   = sp_q - SP_W'(1);
   assign top_ent  = stack_q[sp_top[SA_W-1:0]];
   assign top_idx  = idx_of(top_ent[7:0], top_ent[15:8]);
   assign eligible = !tried[scan_idx] &&
                     (!PARITY_HUNT || scan_phase2 || !(scan_x[0] ^ scan_y[0]));
   assign iss_idx  = idx_of(iss_x, iss_y);

   // Neighbours in push order W, S, E, N so that pops return N, E, S, W.
   always_comb begin
      nb_ent[0] = {shot_y, shot_x - 8'd1};
      nb_ent[1] = {shot_y + 8'd1, shot_x};
      nb_ent[2] = {shot_y, shot_x + 8'd1};
      nb_ent[3] = {shot_y - 8'd1, shot_x};
      nb_ok[0]  = (shot_x != 8'd0) && !tried[idx_of(nb_ent[0][7:0], nb_ent[0][15:8])];
      nb_ok[1]  = (shot_y != DMAX) && !tried[idx_of(nb_ent[1][7:0], nb_ent[1][15:8])];
      nb_ok[2]  = (shot_x != DMAX) && !tried[idx_of(nb_ent[2][7:0], nb_ent[2][15:8])];
      nb_ok[3]  = (shot_y != 8'd0) && !tried[idx_of(nb_ent[3][7:0], nb_ent[3][15:8])];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_CLEAR;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      do_issue   = 1'b0;
      iss_mode   = 1'b0;
      iss_x      = '0;
      iss_y      = '0;
      do_pop     = 1'b0;
      hunt_load  = 1'b0;
      scan_step  = 1'b0;
      phase_set  = 1'b0;
      hunt_fail  = 1'b0;
      case (state)
         S_CLEAR: if (clr_idx == LAST_IDX) next_state = S_IDLE;
         S_IDLE: begin
            if (clear_req) next_state = S_CLEAR;
            else if (start_req) begin
               if (sp_q != '0) next_state = S_TARGET;
               else begin
                  next_state = S_HUNT;
                  hunt_load  = 1'b1;
               end
            end
         end
         S_TARGET: begin
            if (sp_q == '0) begin
               next_state = S_HUNT;
               hunt_load  = 1'b1;
            end else begin
               do_pop = 1'b1;
               if (!tried[top_idx]) begin
                  do_issue   = 1'b1;
                  iss_mode   = 1'b1;
                  iss_x      = top_ent[7:0];
                  iss_y      = top_ent[15:8];
                  next_state = S_DONE;
               end
            end
         end
         S_HUNT: begin
            if (eligible) begin
               do_issue   = 1'b1;
               iss_x      = scan_x;
               iss_y      = scan_y;
               next_state = S_DONE;
            end else if (scan_cnt == LAST_IDX) begin
               if (PARITY_HUNT && !scan_phase2) begin
                  phase_set = 1'b1;
                  scan_step = 1'b1;
               end else begin
                  hunt_fail  = 1'b1;
                  next_state = S_DONE;
               end
            end else begin
               scan_step = 1'b1;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_CLEAR;
      endcase
   end

   // ---------------- target stack ----------------
   always_comb begin
      stack_d = stack_q;
      sp_d    = sp_q;
      if (clear_req || (result_apply && data_in[1])) begin
         sp_d = '0;
      end else if (result_apply && data_in[0]) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (nb_ok[k] && (sp_d < SP_FULL)) begin
               stack_d[sp_d[SA_W-1:0]] = nb_ent[k];
               sp_d = sp_d + SP_W'(1);
            end
         end
      end else if (do_pop) begin
         sp_d = sp_top;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr        <= 16'hACE1;
         shot_valid  <= 1'b0;
         shot_mode   <= 1'b0;
         shot_x      <= '0;
         shot_y      <= '0;
         shot_count  <= '0;
         stack_q     <= '{default: '0};
         sp_q        <= '0;
         clr_idx     <= '0;
         scan_idx    <= '0;
         scan_cnt    <= '0;
         scan_x      <= '0;
         scan_y      <= '0;
         scan_phase2 <= 1'b0;
      end else begin
         stack_q <= stack_d;
         sp_q    <= sp_d;
         if (state == S_CLEAR)
            clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + IDX_W'(1);
         if (clear_req) begin
            clr_idx    <= '0;
            shot_count <= '0;
         end
         if (seed_wr)
            lfsr <= (data_in[15:0] == 16'h0000) ? 16'hACE1 : data_in[15:0];
         if (result_wr) shot_valid <= 1'b0;
         if (hunt_load) begin
            scan_idx    <= start_idx;
            scan_x      <= start_x;
            scan_y      <= start_y;
            scan_cnt    <= '0;
            scan_phase2 <= 1'b0;
         end else if (scan_step) begin
            if (scan_idx == LAST_IDX) begin
               scan_idx <= '0;
               scan_x   <= '0;
               scan_y   <= '0;
            end else if (scan_x == DMAX) begin
               scan_idx <= scan_idx + IDX_W'(1);
               scan_x   <= '0;
               scan_y   <= scan_y + 8'd1;
            end else begin
               scan_idx <= scan_idx + IDX_W'(1);
               scan_x   <= scan_x + 8'd1;
            end
            scan_cnt <= phase_set ? '0 : scan_cnt + IDX_W'(1);
            if (phase_set) scan_phase2 <= 1'b1;
         end
         if (do_issue) begin
            shot_valid <= 1'b1;
            shot_mode  <= iss_mode;
            shot_x     <= iss_x;
            shot_y     <= iss_y;
            if (shot_count != 16'hFFFF) shot_count <= shot_count + 16'd1;
            lfsr <= lfsr_next;
         end
         if (hunt_fail) shot_valid <= 1'b0;
      end
   end

   // Bitmap is not reset: the CLEAR state zeroes it after any reset.
   always_ff @(posedge clock) begin
      if (state == S_CLEAR) tried[clr_idx] <= 1'b0;
      if (do_issue)         tried[iss_idx] <= 1'b1;
   end

   // ---------------- read mux ----------------
   always_comb begin
      rdata = '0;
      if (acc_rd) begin
         case (addr)
            4'd3:    rdata = {shot_valid, shot_mode, 14'd0, shot_y, shot_x};
            4'd4:    rdata = {wait_request, 15'd0, shot_count};
            default: rdata = '0;
         endcase
      end
      data_out = DATA_W'(rdata);
   end

endmodule

// File: tb/tb_ai_shot_engine.sv
// tb_ai_shot_engine: directed, table-driven checks of ai_shot_engine on a
// 10x10 board (dut0) and a 2x2 board (dut1) sharing one bus via a select.
module tb_ai_shot_engine;

   logic        clock = 1'b0;
   logic        rst0_n = 1'b0, rst1_n = 1'b0;
   logic        sel = 1'b0;
   logic [3:0]  addr = '0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [31:0] din = '0;
   logic        w0, w1;
   logic [31:0] d0, d1;
   logic        wr0, rd0, wr1, rd1, wait_m;
   logic [31:0] dout_m;

   int n_pass = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   assign wr0    = wr & ~sel;
   assign rd0    = rd & ~sel;
   assign wr1    = wr & sel;
   assign rd1    = rd & sel;
   assign wait_m = sel ? w1 : w0;
   assign dout_m = sel ? d1 : d0;

   ai_shot_engine #(.BOARD_DIM(10), .STACK_DEPTH(16), .DATA_W(32)) u_dut0 (
      .clock(clock), .reset_n(rst0_n), .addr(addr), .write_en(wr0), .read_en(rd0),
      .data_in(din), .wait_request(w0), .data_out(d0));

   ai_shot_engine #(.BOARD_DIM(2), .STACK_DEPTH(16), .DATA_W(32)) u_dut1 (
      .clock(clock), .reset_n(rst1_n), .addr(addr), .write_en(wr1), .read_en(rd1),
      .data_in(din), .wait_request(w1), .data_out(d1));

   typedef struct {
      bit          s;
      bit          r;
      logic [3:0]  a;
      logic [31:0] d;
      logic [31:0] m;
      string       nm;
   } vec_t;

   vec_t tbl[$];

`ifdef AI_PARITY_HUNT_EN
   localparam logic [31:0] SMALL_MASK = 32'h8000_0000;
   localparam logic [31:0] SEED1_SHOT = 32'h8000_0002;
`else
   localparam logic [31:0] SMALL_MASK = 32'hFFFF_FFFF;
   localparam logic [31:0] SEED1_SHOT = 32'h8000_0001;
`endif

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic addv(input bit s, input bit r, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] m, input string nm);
      vec_t v;
      v.s = s; v.r = r; v.a = a; v.d = d; v.m = m; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic bus(input bit is_rd, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] q);
      int n;
      n = 0;
      q = '0;
      @(negedge clock);
      while (wait_m && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (wait_m) begin
         n_total++;
         $display("FAIL bus_timeout: wait_request still %b after %0d cycles", wait_m, n);
         return;
      end
      addr = a; din = d; rd = is_rd; wr = !is_rd;
      #1 q = dout_m;
      @(posedge clock);
      #1 rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
   endtask

   task automatic measure_clear(input string nm, input int exp);
      int cyc;
      cyc = 0;
      while (wait_m && cyc < 1000) begin
         @(posedge clock);
         #1 cyc++;
      end
      chk(nm, 32'(cyc), 32'(exp));
   endtask

   initial begin
      logic [31:0] q;

      // ---- stimulus table ----
      addv(0, 1, 4'd3, 32'h0000_0000, '1, "shot_after_reset");
      addv(0, 1, 4'd4, 32'h0000_0000, '1, "status_after_reset");
      addv(0, 1, 4'd7, 32'h0000_0000, '1, "unmapped_read");
      addv(0, 0, 4'd1, 32'h0000_0001, '1, "seed1");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, SEED1_SHOT,    '1, "hunt_seed1");
      addv(0, 1, 4'd4, 32'h0000_0001, '1, "count_one");
`ifndef AI_PARITY_HUNT_EN
      addv(0, 0, 4'd0, 32'h0000_0002, '1, "clear");
      addv(0, 0, 4'd1, 32'h0000_0002, '1, "seed2");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'h8000_0002, '1, "hunt_seed2");
      addv(0, 0, 4'd2, 32'h0000_0001, '1, "result_hit");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'hC000_0003, '1, "target_east");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'hC000_0102, '1, "target_south");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'hC000_0001, '1, "target_west");
      addv(0, 1, 4'd4, 32'h0000_0004, '1, "count_four");
      addv(0, 0, 4'd0, 32'h0000_0002, '1, "clear");
      addv(0, 0, 4'd1, 32'h0000_0002, '1, "seed2");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'h8000_0002, '1, "hunt_seed2b");
      addv(0, 0, 4'd2, 32'h0000_0001, '1, "result_hit");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'hC000_0003, '1, "target_east_b");
      addv(0, 0, 4'd2, 32'h0000_0003, '1, "result_sunk");
      addv(0, 1, 4'd3, 32'h4000_0003, '1, "valid_cleared");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'h8000_0000, '1, "hunt_after_sunk");
      addv(0, 0, 4'd2, 32'h0000_0000, '1, "result_miss");
      addv(0, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(0, 1, 4'd3, 32'h8000_0001, '1, "stack_empty_hunt");
      addv(0, 1, 4'd4, 32'h0000_0004, '1, "count_after_sunk");
`endif
      addv(1, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(1, 1, 4'd3, 32'h8000_0001, SMALL_MASK, "small_shot1");
      addv(1, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(1, 1, 4'd3, 32'h8000_0000, SMALL_MASK, "small_shot2");
      addv(1, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(1, 1, 4'd3, 32'h8000_0100, SMALL_MASK, "small_shot3");
      addv(1, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(1, 1, 4'd3, 32'h8000_0101, SMALL_MASK, "small_shot4");
      addv(1, 0, 4'd0, 32'h0000_0001, '1, "start");
      addv(1, 1, 4'd3, 32'h0000_0000, 32'h8000_0000, "small_exhausted");
      addv(1, 1, 4'd4, 32'h0000_0004, '1, "small_count");

      // ---- reset release and clear timing ----
      repeat (3) @(negedge clock);
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      #1 chk("wait_after_release", 32'(wait_m), 32'd1);
      measure_clear("clear_cycles_100", 100);

      // ---- table ----
      foreach (tbl[i]) begin
         sel = tbl[i].s;
         bus(tbl[i].r, tbl[i].a, tbl[i].d, q);
         if (tbl[i].r) chk(tbl[i].nm, q & tbl[i].m, tbl[i].d & tbl[i].m);
      end

      // ---- dut0: reset mid-operation with a pending hit on the stack ----
      sel = 1'b0;
      bus(0, 4'd2, 32'h1, q);
      bus(0, 4'd0, 32'h1, q);
      rst0_n = 1'b0;
      rd = 1'b1; addr = 4'd3;
      #1 chk("abort_wait_high", 32'(wait_m), 32'd1);
      chk("abort_dout_zero", dout_m, 32'h0);
      rd = 1'b0; addr = '0;
      @(negedge clock);
      @(negedge clock);
      rst0_n = 1'b1;
      measure_clear("abort_clear_100", 100);
      bus(1, 4'd3, 32'h0, q); chk("abort_shot_zero", q, 32'h0);
      bus(1, 4'd4, 32'h0, q); chk("abort_count_zero", q, 32'h0);
      bus(0, 4'd0, 32'h1, q);
      bus(1, 4'd3, 32'h0, q); chk("abort_no_target", q, 32'h8000_0907);

      // ---- dut1: reset while hunting an exhausted board ----
      sel = 1'b1;
      bus(0, 4'd0, 32'h1, q);
      rst1_n = 1'b0;
      rd = 1'b1; addr = 4'd3;
      #1 chk("hunt_abort_wait", 32'(wait_m), 32'd1);
      chk("hunt_abort_dout", dout_m, 32'h0);
      rd = 1'b0; addr = '0;
      @(negedge clock);
      rst1_n = 1'b1;
      measure_clear("small_clear_4", 4);
      bus(1, 4'd3, 32'h0, q); chk("small_shot_zero", q, 32'h0);
      bus(1, 4'd4, 32'h0, q); chk("small_count_zero", q, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ai_shot_engine.md
Name: ai_shot_engine

Overview:
- Parametrised successor to the fixed-board BattleChip AI opponent.
- Memory-mapped slave that produces the AI's next shot coordinate on a configurable square board.
- Uses hunt mode (LFSR-seeded scan of untried cells) and target mode (LIFO stack of neighbours of reported hits).
- Sits on the HPS-to-FPGA bus; software writes the seed and shot results, starts a shot, then reads the coordinate.

Parameters:
- BOARD_DIM, 10, board side length; cells N = BOARD_DIM*BOARD_DIM, range 2..16.
- STACK_DEPTH, 16, target-mode neighbour stack entries.
- DATA_W, 32, bus data width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- addr  in  4  register select
- write_en  in  1  write strobe
- read_en  in  1  read strobe
- data_in  in  DATA_W  write data
- wait_request  out  1  high = access not accepted, master holds
- data_out  out  DATA_W  read data

Behaviour:
- Register map:
  - 0 CTRL (W): bit0 start shot; bit1 clear board.
  - 1 SEED (W): 16-bit LFSR seed; 0 is replaced by 0xACE1.
  - 2 RESULT (W): bit0 hit, bit1 sunk, for the last issued shot.
  - 3 SHOT (R): bit31 valid, bit30 mode (1 = target), [15:8] y, [7:0] x.
  - 4 STATUS (R): bit31 busy, [15:0] shots issued.
  - Other addresses: reads return 0, writes ignored.
- Access acceptance: an access is accepted when strobe && !wait_request. data_out is combinational from the selected register in the accepted cycle, and 0 otherwise.
- Storage: tried[N] bitmap; index = y*BOARD_DIM + x.
- FSM states: CLEAR, IDLE, HUNT, TARGET, DONE.
- Reset: state=CLEAR, LFSR=0xACE1, stack empty, SHOT=0, count=0, data_out=0, wait_request=1.
  - CLEAR zeroes one cell per cycle (N cycles), then goes to IDLE.
  - wait_request is high in every state except IDLE.
- CTRL.start in IDLE: next cycle TARGET if the stack is non-empty, else HUNT.
- CTRL.clear in IDLE: enters CLEAR, empties the stack, zeroes the count. Clear has priority over start if both bits are set.
- TARGET:
  - Pop top entry. If already tried, discard it and pop again next cycle.
  - If the stack empties, go to HUNT.
  - Otherwise issue the shot: 2 cycles from accept.
- HUNT:
  - Start index = LFSR[clog2(N)-1:0], minus N if >= N.
  - Scan +1 per cycle, wrapping N-1 -> 0, until an untried eligible cell is found.
  - Full wrap with no hit: SHOT.valid=0, count unchanged, go to DONE.
  - Worst case N+2 cycles.
- Issue: mark the cell tried, load SHOT (valid=1), increment count (saturating at 0xFFFF), step the 16-bit Galois LFSR (taps 0xB400) once, then DONE -> IDLE.
- RESULT write in IDLE:
  - Applies only if SHOT.valid.
  - hit && !sunk: push in-bounds, untried neighbours in order W, S, E, N, so pops come out N, E, S, W. N = y-1, S = y+1.
  - sunk: empty the stack.
  - Miss: no action.
  - Clears SHOT.valid.
- Stack full: further pushes are dropped silently.
- Start without an intervening RESULT write: the previous shot is treated as a miss.
- Async reset mid-operation aborts everything and re-enters CLEAR.

Optional Feature:
- Macro AI_PARITY_HUNT_EN.
- When defined: HUNT accepts only cells with (x+y) even. Once a full wrap finds none, it re-scans accepting any untried cell, which costs up to 2N+2 cycles.
- When undefined: any untried cell is eligible.
- TARGET mode is unaffected either way.

Test Plan:
- Reset release -> wait_request=1 for exactly 100 cycles (BOARD_DIM=10), then 0. Read SHOT=0, STATUS=0.
- SEED=1, CTRL=1, read SHOT:
  - Without macro: 0x80000001 (x=1, y=0).
  - With macro: 0x80000002 (x=2, y=0).
  - STATUS count=1.
- After shot (2,0), RESULT=1, then three starts -> SHOT 0xC0000003, 0xC0000102, 0xC0000001 (x=1, y=0). Run without the macro with a fresh seed so (1,0) is untried.
- Hit then RESULT=3 (sunk) -> next start yields hunt mode (bit30=0) and the stack is empty.
- BOARD_DIM=2: four starts return the four distinct cells. Fifth start -> SHOT.valid=0, STATUS count=4.
- Assert reset_n low during HUNT -> wait_request=1 immediately, SHOT=0, count=0. After N cycles wait_request=0 and a prior hit does not produce a target-mode shot.
